// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide bus target behind the core memory controller.
// It backs a RAM region and a small I/O region. The I/O region holds the
// UART tx/rx FIFOs and a sticky halt register. Read data arrives one cycle
// after the address.
module mem_io_responder #(
    parameter int ADDR_W   = 17,
    parameter int IO_BIT   = 17,
    parameter int FIFO_LOG = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ad,
    input  logic        wr,
    input  logic [7:0]  out,
    output logic [7:0]  in,
    output logic        io_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        halt,
    output logic        tx_overflow,
    output logic        rx_overflow
);

    localparam int             DEPTH    = 2 ** FIFO_LOG;
    localparam logic [FIFO_LOG:0] FULL_CNT = (FIFO_LOG + 1)'(DEPTH);
    localparam logic [FIFO_LOG:0] HIGH_CNT = (FIFO_LOG + 1)'(DEPTH - 1);

    // NOTE: storage arrays carry no reset, so they can map onto plain RAM cells.
    logic [7:0] ram_q    [2 ** ADDR_W];
    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];

    logic [FIFO_LOG-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [FIFO_LOG:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]          in_q, rd_data;
    logic [31:0]         last_ad_q;
    logic                last_wr_q;
    logic                io_full_q, halt_q, tx_ovf_q, rx_ovf_q;

    logic                io_sel;
    logic [2:0]          io_off;
    logic [ADDR_W-1:0]   ram_addr;
    logic                io_wr_tx, io_wr_halt, io_rd_rx, first_rd;
    logic                tx_full, tx_push, tx_pop, tx_drop;
    logic                rx_full, rx_nonempty, rx_push, rx_pop, rx_drop;

    // Address decode and bus strobes.
    assign io_sel     = ad[IO_BIT];
    assign io_off     = ad[2:0];
    assign ram_addr   = ad[ADDR_W-1:0];
    assign io_wr_tx   = wr & io_sel & (io_off == 3'd0);
    assign io_wr_halt = wr & io_sel & (io_off == 3'd4);
    assign io_rd_rx   = ~wr & io_sel & (io_off == 3'd0);
    // A held read address pops once. Only a new address, or a read that
    // follows a write, counts as a fresh access.
    assign first_rd   = (ad != last_ad_q) | last_wr_q;

    // The tx FIFO accepts a push when full if a pop frees a slot in the same cycle.
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_push  = io_wr_tx & (~tx_full | tx_pop);
    assign tx_drop  = io_wr_tx & tx_full & ~tx_pop;
    assign tx_cnt_d = tx_cnt_q + (FIFO_LOG + 1)'(tx_push) - (FIFO_LOG + 1)'(tx_pop);

    // The rx FIFO is filled by the UART and drained by bus reads of offset 0.
    assign rx_full     = (rx_cnt_q == FULL_CNT);
    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_push     = rx_valid & ~rx_full;
    assign rx_drop     = rx_valid & rx_full;
    assign rx_pop      = io_rd_rx & first_rd & rx_nonempty;
    assign rx_cnt_d    = rx_cnt_q + (FIFO_LOG + 1)'(rx_push) - (FIFO_LOG + 1)'(rx_pop);

    // Select the read data for the current address, to be registered into `in`.
    always_comb begin
        rd_data = 8'h00;
        if (!io_sel) begin
            rd_data = ram_q[ram_addr];
        end else begin
            case (io_off)
                3'd0:    rd_data = rx_nonempty ? rx_mem_q[rx_rptr_q] : 8'h00;
                3'd4:    rd_data = {5'b0, halt_q, tx_full, rx_nonempty};
                default: rd_data = 8'h00;
            endcase
        end
    end

    // Write RAM and FIFO storage; these arrays are never reset.
    always_ff @(posedge clk) begin
        if (wr && !io_sel) ram_q[ram_addr] <= out;
        if (tx_push)       tx_mem_q[tx_wptr_q] <= out;
        if (rx_push)       rx_mem_q[rx_wptr_q] <= rx_data;
    end

    // Control state: pointers, counts, read register, status and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            in_q      <= 8'h00;
            last_ad_q <= '0;
            last_wr_q <= 1'b0;
            io_full_q <= 1'b0;
            halt_q    <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            if (!wr) in_q <= rd_data;
            last_ad_q <= ad;
            last_wr_q <= wr;
            io_full_q <= (tx_cnt_d >= HIGH_CNT);
            if (io_wr_halt) halt_q   <= 1'b1;
            if (tx_drop)    tx_ovf_q <= 1'b1;
            if (rx_drop)    rx_ovf_q <= 1'b1;
        end
    end

    assign in          = in_q;
    assign io_full     = io_full_q;
    assign tx_valid    = (tx_cnt_q != '0);
    assign tx_data     = tx_valid ? tx_mem_q[tx_rptr_q] : 8'h00;
    assign halt        = halt_q;
    assign tx_overflow = tx_ovf_q;
    assign rx_overflow = rx_ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder: RAM, tx/rx FIFOs, halt and reset.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ad;
    logic        wr;
    logic [7:0]  out;
    logic [7:0]  in;
    logic        io_full, tx_valid, tx_ready, rx_valid, halt, tx_overflow, rx_overflow;
    logic [7:0]  tx_data, rx_data;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_io_responder dut (
        .clk         (clk),
        .rst         (rst),
        .ad          (ad),
        .wr          (wr),
        .out         (out),
        .in          (in),
        .io_full     (io_full),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .halt        (halt),
        .tx_overflow (tx_overflow),
        .rx_overflow (rx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        ad  = a;
        wr  = w;
        out = d;
        cyc();
    endtask

    initial begin
        rst = 1'b0; ad = '0; wr = 1'b0; out = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        #3;
        chk("rst_in", in, 8'h00);
        chk("rst_io_full", io_full, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_flags", {halt, tx_overflow, rx_overflow}, 3'b000);
        cyc();
        cyc();
        rst = 1'b1;

        // RAM writes, then reads on consecutive cycles.
        bus(32'h0001_0, 1'b1, 8'hA5);
        bus(32'h0001_1, 1'b1, 8'h3C);
        chk("in_hold_on_write", in, 8'h00);
        bus(32'h0001_0, 1'b0, 8'h00);
        chk("ram_rd_10", in, 8'hA5);
        bus(32'h0001_1, 1'b0, 8'h00);
        chk("ram_rd_11", in, 8'h3C);
        bus(32'h0000_20, 1'b1, 8'h77);
        bus(32'h0000_20, 1'b0, 8'h00);
        chk("ram_raw_b2b", in, 8'h77);
        bus(32'h0001_0, 1'b0, 8'h00);
        bus(32'h3000_2, 1'b0, 8'h00);
        chk("io_unused_off", in, 8'h00);

        // Fill tx, then push and pop in the same cycle while full.
        for (int i = 0; i < 8; i++) bus(32'h3000_0, 1'b1, 8'h61 + 8'(i));
        chk("full_io_full", io_full, 1'b1);
        chk("full_head", tx_data, 8'h61);
        ad = 32'h3000_0; wr = 1'b1; out = 8'h50; tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        chk("poppush_no_ovf", tx_overflow, 1'b0);
        chk("poppush_io_full", io_full, 1'b1);
        chk("poppush_head", tx_data, 8'h62);
        bus(32'h3000_4, 1'b0, 8'h00);
        chk("status_txfull", in, 8'h02);
        tx_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("poppush_drain%0d", i), tx_data, 8'h62 + 8'(i));
            cyc();
        end
        chk("poppush_last", tx_data, 8'h50);
        cyc();
        chk("poppush_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Overflow: the io_full threshold, then a dropped 9th byte.
        for (int i = 0; i < 8; i++) begin
            bus(32'h3000_0, 1'b1, 8'h41 + 8'(i));
            if (i == 5) chk("io_full_after6", io_full, 1'b0);
            if (i == 6) chk("io_full_after7", io_full, 1'b1);
        end
        chk("no_ovf_at8", tx_overflow, 1'b0);
        bus(32'h3000_0, 1'b1, 8'h49);
        chk("tx_ovf_set", tx_overflow, 1'b1);
        ad = 32'h0001_0; wr = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid%0d", i), tx_valid, 1'b1);
            chk($sformatf("drain_data%0d", i), tx_data, 8'h41 + 8'(i));
            cyc();
        end
        chk("drain_empty", tx_valid, 1'b0);
        chk("drain_io_full", io_full, 1'b0);
        tx_ready = 1'b0;

        // rx: a held read pops once.
        rx_valid = 1'b1; rx_data = 8'h31; cyc();
        rx_data = 8'h32; cyc();
        rx_valid = 1'b0;
        bus(32'h3000_0, 1'b0, 8'h00);
        chk("rx_first", in, 8'h31);
        cyc();
        cyc();
        bus(32'h3000_4, 1'b0, 8'h00);
        chk("rx_status", in, 8'h01);
        bus(32'h3000_0, 1'b0, 8'h00);
        chk("rx_second", in, 8'h32);
        bus(32'h3000_4, 1'b0, 8'h00);
        chk("rx_status_empty", in, 8'h00);
        bus(32'h3000_0, 1'b0, 8'h00);
        chk("rx_empty_read", in, 8'h00);
        chk("rx_no_ovf", rx_overflow, 1'b0);

        // Halt register.
        bus(32'h3000_4, 1'b1, 8'hFF);
        chk("halt_set", halt, 1'b1);
        bus(32'h3000_4, 1'b0, 8'h00);
        chk("halt_status", in, 8'h04);

        // Reset while busy: tx_valid and `in` drop at once; RAM keeps its data.
        bus(32'h0001_234, 1'b1, 8'hC3);
        for (int i = 0; i < 3; i++) bus(32'h3000_0, 1'b1, 8'h70 + 8'(i));
        bus(32'h0001_0, 1'b0, 8'h00);
        chk("pre_rst_in", in, 8'hA5);
        #2 rst = 1'b0;
        #1;
        chk("async_tx_valid", tx_valid, 1'b0);
        chk("async_in", in, 8'h00);
        chk("async_flags", {halt, tx_overflow}, 2'b00);
        cyc();
        rst = 1'b1;
        bus(32'h0001_234, 1'b0, 8'h00);
        chk("ram_survives_rst", in, 8'hC3);

        // rx overflow: nine pushes into an eight-entry FIFO.
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h80 + 8'(i);
            cyc();
        end
        rx_valid = 1'b0;
        chk("rx_ovf_set", rx_overflow, 1'b1);
        bus(32'h3000_0, 1'b0, 8'h00);
        chk("rx_ovf_head", in, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Byte-wide bus target on the far side of the core memory controller.
- Answers the controller's address, write strobe and write-data byte with a read-data byte one cycle later.
- Backs a RAM region and a small memory-mapped I/O region holding UART tx/rx FIFOs and a halt register.
- Sits between the controller and the board RAM / UART wrapper.

Parameters:
- ADDR_W, 17, RAM address bits; RAM depth is 2**ADDR_W bytes.
- IO_BIT, 17, address bit that selects the I/O region when set.
- FIFO_LOG, 3, log2 of tx and rx FIFO depth (8 entries each).

Ports:
- clk  in  1  clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ad  in  32  byte address from the controller; only bits [IO_BIT:0] are decoded.
- wr  in  1  1 = write the addressed byte this cycle, 0 = read.
- out  in  8  write-data byte from the controller, valid with wr = 1.
- in  out  8  read-data byte to the controller, registered.
- io_full  out  1  tx FIFO holds at least 2**FIFO_LOG-1 entries; the controller stalls I/O writes on this.
- tx_valid  out  1  tx FIFO not empty.
- tx_data  out  8  tx FIFO head byte.
- tx_ready  in  1  UART accepts tx_data this cycle.
- rx_valid  in  1  UART presents a received byte.
- rx_data  in  8  received byte.
- halt  out  1  sticky; set by a write to the halt register.
- tx_overflow  out  1  sticky; a tx byte was dropped.
- rx_overflow  out  1  sticky; an rx byte was dropped.

Behaviour:
- Reset (async, rst = 0): all outputs and status registers go to 0: in, io_full, tx_valid, tx_data, halt, tx_overflow, rx_overflow, FIFO pointers/counts, last-address register. RAM contents are not cleared.
- Decode: ad[IO_BIT] = 0 selects RAM at ad[ADDR_W-1:0]. ad[IO_BIT] = 1 selects I/O on ad[2:0]:
  - 0 = UART data.
  - 4 = status / halt.
  - Any other offset reads 0x00 and ignores writes.
- RAM write: wr = 1 stores `out` at the address on this edge. `in` is unchanged on a write cycle.
- RAM read: wr = 0; `in` = mem[addr] on the next edge (1-cycle latency).
- Back-to-back: a read of an address written in the previous cycle returns the new byte.
- I/O write, offset 0:
  - Pushes `out` into the tx FIFO if not full.
  - If full, the byte is dropped and tx_overflow is set.
- I/O write, offset 4: sets halt. Any data value.
- I/O read, offset 0:
  - `in` = rx FIFO head next cycle; the entry is popped if non-empty.
  - If empty, `in` = 0x00 and nothing is popped.
  - Pop only on the first read cycle of that address: pop when the current ad differs from the registered previous-cycle ad, or the previous cycle was a write.
  - A held read address therefore pops exactly once.
- I/O read, offset 4: `in` = {5'b0, halt, tx FIFO full, rx FIFO non-empty}.
- tx drain:
  - tx_valid = tx count != 0; tx_data = head.
  - Pop on a cycle with tx_valid & tx_ready.
  - Push and pop in the same cycle leave the count unchanged. Pop-then-push on a full FIFO is legal (count stays full, no overflow).
- rx fill:
  - rx_valid pushes rx_data when the rx FIFO is not full, else the byte is dropped and rx_overflow is set.
  - Simultaneous push and bus pop leave the count unchanged.
  - Pop on an empty FIFO with a concurrent push returns 0x00; the pushed byte stays.
- Pointers wrap modulo 2**FIFO_LOG; the count is FIFO_LOG+1 bits wide.
- io_full is registered from the next-state count.
- Sticky flags clear only on reset.
- Reset mid-operation abandons any in-flight read. FIFOs empty immediately; tx_valid drops asynchronously.

Test Plan:
- Write 0xA5 to 0x00010, then 0x3C to 0x00011; read 0x00010, 0x00011 on consecutive cycles -> `in` = 0xA5 then 0x3C, each one cycle after its address.
- 8 writes of 0x41..0x48 to 0x30000 with tx_ready = 0 -> io_full = 1 after the 7th write; the 9th write (0x49) is dropped and tx_overflow = 1. Raise tx_ready -> tx_data 0x41..0x48 in order, then tx_valid = 0.
- rx_valid pulses 0x31, 0x32; hold ad = 0x30000, wr = 0 for 3 cycles, then move to 0x30004 and back to 0x30000 -> first read 0x31 with a single pop; status = 0x01; next read 0x32; a further read returns 0x00.
- Write 0xFF to 0x30004 -> halt = 1 the next cycle; status read = 0x04.
- Tx FIFO full, tx_ready = 1 and an I/O write of 0x50 in the same cycle -> count stays 8, no overflow, 0x50 emitted last.
- Assert rst = 0 mid-burst with 3 tx entries queued -> tx_valid = 0 and `in` = 0x00 immediately. After release, an RAM byte written before reset still reads back.
